// File: rtl/cp_phase_ctrl.sv
// Two-phase non-overlapping charge-pump controller with comparator pulse skipping.
// Latency: cmp_hi reaches the FSM after 2 clk; phases are registered, so phi1/phi2 follow the state with no decode glitches.
// Backpressure: none; en=0 forces IDLE on the next edge and cmp_s=1 holds the pump in DEAD2 until the output droops.
module cp_phase_ctrl #(
    parameter int DIV_W  = 8,
    parameter int DEAD_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div,
    input  logic [DEAD_W-1:0] dead,
    input  logic              cmp_hi,
    input  logic              clr,
    output logic              phi1,
    output logic              phi2,
    output logic              running,
    output logic              in_reg,
    output logic [CNT_W-1:0]  pulse_cnt
);

    localparam int PC_W = (DIV_W > DEAD_W) ? DIV_W : DEAD_W;

    typedef enum logic [2:0] {
        IDLE,
        PH1,
        DEAD1,
        PH2,
        DEAD2
    } state_t;

    state_t           state;
    logic [PC_W-1:0]  phase_cnt;
    logic             cmp_s1;
    logic             cmp_s;
    logic             cnt_zero;
    logic             ph1_entry;
    logic [CNT_W-1:0] cnt_inc;
    logic [PC_W-1:0]  div_ext;
    logic [PC_W-1:0]  dead_ext;

    assign div_ext  = PC_W'(div);
    assign dead_ext = PC_W'(dead);
    assign cnt_zero = (phase_cnt == '0);
    assign in_reg   = cmp_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_s1 <= 1'b0;
            cmp_s  <= 1'b0;
        end else begin
            cmp_s1 <= cmp_hi;
            cmp_s  <= cmp_s1;
        end
    end

    always_comb begin
        ph1_entry = 1'b0;
        if (en && !cmp_s) begin
            if (state == IDLE)
                ph1_entry = 1'b1;
            else if (state == DEAD2 && cnt_zero)
                ph1_entry = 1'b1;
        end
    end

    assign cnt_inc = (&pulse_cnt) ? pulse_cnt : pulse_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt <= '0;
        end else if (clr) begin
            pulse_cnt <= '0;
        end else if (ph1_entry) begin
            pulse_cnt <= cnt_inc;
        end
    end

    // phase_cnt holds the remaining cycles of the current phase minus one;
    // settings are captured only on phase entry so mid-phase input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
            phi1      <= 1'b0;
            phi2      <= 1'b0;
            running   <= 1'b0;
        end else if (!en) begin
            state     <= IDLE;
            phase_cnt <= '0;
            phi1      <= 1'b0;
            phi2      <= 1'b0;
            running   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cmp_s) begin
                        state     <= PH1;
                        phase_cnt <= div_ext;
                        phi1      <= 1'b1;
                        running   <= 1'b1;
                    end
                end
                PH1: begin
                    if (cnt_zero) begin
                        state     <= DEAD1;
                        phase_cnt <= dead_ext;
                        phi1      <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt - PC_W'(1);
                    end
                end
                DEAD1: begin
                    if (cnt_zero) begin
                        state     <= PH2;
                        phase_cnt <= div_ext;
                        phi2      <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt - PC_W'(1);
                    end
                end
                PH2: begin
                    if (cnt_zero) begin
                        state     <= DEAD2;
                        phase_cnt <= dead_ext;
                        phi2      <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt - PC_W'(1);
                    end
                end
                DEAD2: begin
                    // Regulated output: sit here with both phases low until cmp_s drops.
                    if (cnt_zero) begin
                        if (!cmp_s) begin
                            state     <= PH1;
                            phase_cnt <= div_ext;
                            phi1      <= 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - PC_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    phase_cnt <= '0;
                    phi1      <= 1'b0;
                    phi2      <= 1'b0;
                    running   <= 1'b0;
                end
            endcase
        end
    end

endmodule
